// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches 1-3 byte instructions from
// synchronous RAM and hands them to the execute stage until it reports completion.
package instr_fetch_pkg;
  typedef enum logic [2:0] {
    S_RESET          = 3'd0,
    S_INIT           = 3'd1,
    S_LATCH_ADDR     = 3'd2,
    S_READ_BYTE      = 3'd3,
    S_LATCH_BYTE     = 3'd4,
    S_CHK_MORE_BYTES = 3'd5,
    S_EXECUTE        = 3'd6,
    S_HALT           = 3'd7
  } fsm_state_t;

  typedef enum logic [7:0] {
    OP_NOP   = 8'h00,
    OP_HLT   = 8'h01,
    OP_LDA   = 8'h0A,
    OP_LDI_A = 8'h0C
  } opcode_t;
endpackage

module instr_fetch_sequencer
  import instr_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hF000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  exec_done,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_value,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] operand_lo,
  output logic [DATA_WIDTH-1:0] operand_hi,
  output logic                  instr_valid,
  output logic                  illegal_op,
  output logic                  halted,
  output logic [2:0]            state
);

  localparam logic [DATA_WIDTH-1:0] NOP_B = DATA_WIDTH'(OP_NOP);
  localparam logic [DATA_WIDTH-1:0] HLT_B = DATA_WIDTH'(OP_HLT);
  localparam logic [DATA_WIDTH-1:0] LDA_B = DATA_WIDTH'(OP_LDA);
  localparam logic [DATA_WIDTH-1:0] LDI_B = DATA_WIDTH'(OP_LDI_A);

  fsm_state_t st;
  logic [1:0] byte_idx;
  logic [1:0] op_len;
  logic       op_legal;

  assign mem_addr = pc;
  assign state    = st;

  // Instruction length decode; unknown opcodes execute as 1-byte illegal ops.
  always_comb begin
    op_len   = 2'd1;
    op_legal = 1'b1;
    case (opcode)
      NOP_B, HLT_B: op_len = 2'd1;
      LDI_B:        op_len = 2'd2;
      LDA_B:        op_len = 2'd3;
      default:      op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= S_RESET;
      pc          <= '0;
      opcode      <= '0;
      operand_lo  <= '0;
      operand_hi  <= '0;
      byte_idx    <= '0;
      mem_rd      <= 1'b0;
      instr_valid <= 1'b0;
      illegal_op  <= 1'b0;
      halted      <= 1'b0;
    end else begin
      // mem_rd is a one-cycle strobe raised on every entry to S_LATCH_ADDR.
      mem_rd <= 1'b0;
      case (st)
        S_RESET: st <= S_INIT;
        S_INIT: begin
          pc       <= RESET_VECTOR;
          byte_idx <= '0;
          mem_rd   <= 1'b1;
          st       <= S_LATCH_ADDR;
        end
        S_LATCH_ADDR: st <= S_READ_BYTE;
        S_READ_BYTE: begin
          case (byte_idx)
            2'd0: begin
              opcode     <= mem_rdata;
              operand_lo <= '0;
              operand_hi <= '0;
            end
            2'd1:    operand_lo <= mem_rdata;
            default: operand_hi <= mem_rdata;
          endcase
          st <= S_LATCH_BYTE;
        end
        S_LATCH_BYTE: begin
          pc       <= pc + ADDR_WIDTH'(1);
          byte_idx <= byte_idx + 2'd1;
          st       <= S_CHK_MORE_BYTES;
        end
        S_CHK_MORE_BYTES: begin
          if (opcode == HLT_B) begin
            halted <= 1'b1;
            st     <= S_HALT;
          end else if (byte_idx < op_len) begin
            mem_rd <= 1'b1;
            st     <= S_LATCH_ADDR;
          end else begin
            byte_idx    <= '0;
            instr_valid <= 1'b1;
            illegal_op  <= ~op_legal;
            st          <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (exec_done) begin
            if (pc_load) pc <= pc_load_value;
            instr_valid <= 1'b0;
            illegal_op  <= 1'b0;
            mem_rd      <= 1'b1;
            st          <= S_LATCH_ADDR;
          end
        end
        S_HALT: st <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Randomized bench for instr_fetch_sequencer against an instruction-level model
// of the fetch rules (length by opcode, wrapping PC, 4 cycles per byte).
module tb_instr_fetch_sequencer;
  localparam logic [15:0] RV = 16'hF000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  mem_rdata = 8'h00;
  logic        exec_done = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_value = 16'h0000;
  logic [15:0] mem_addr, pc;
  logic        mem_rd, instr_valid, illegal_op, halted;
  logic [7:0]  opcode, operand_lo, operand_hi;
  logic [2:0]  state;

  logic [7:0]  ram [0:65535];
  logic [15:0] mpc;
  int checks = 0, errors = 0;

  instr_fetch_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .exec_done(exec_done),
    .pc_load(pc_load), .pc_load_value(pc_load_value), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .pc(pc), .opcode(opcode), .operand_lo(operand_lo),
    .operand_hi(operand_hi), .instr_valid(instr_valid), .illegal_op(illegal_op),
    .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int ilen(input logic [7:0] op);
    case (op)
      8'h0C:   return 2;
      8'h0A:   return 3;
      default: return 1;
    endcase
  endfunction

  function automatic bit legal(input logic [7:0] op);
    return op inside {8'h00, 8'h01, 8'h0A, 8'h0C};
  endfunction

  task automatic put(input logic [15:0] a, input logic [7:0] op, input logic [7:0] b1,
                     input logic [7:0] b2);
    logic [15:0] a1, a2;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    ram[a] = op;
    if (ilen(op) >= 2) ram[a1] = b1;
    if (ilen(op) == 3) ram[a2] = b2;
  endtask

  // Holds reset, checks the reset state, releases it and stops in the first S_LATCH_ADDR.
  task automatic reset_start();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst.state", state, 0);
    chk("rst.pc", pc, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.rd", mem_rd, 0);
    chk("rst.op", {opcode, operand_lo, operand_hi}, 0);
    chk("rst.flags", {instr_valid, illegal_op, halted}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("init.state", state, 1);
    chk("init.rd", mem_rd, 0);
    @(negedge clk);
    mpc = RV;
  endtask

  // Entered at the negedge of the first S_LATCH_ADDR of an instruction at mpc.
  task automatic check_fetch(input string tag, input bit early);
    logic [7:0]  op, lo, hi;
    logic [15:0] a1, a2;
    int n, len;
    op  = ram[mpc];
    len = ilen(op);
    a1  = mpc + 16'd1;
    a2  = mpc + 16'd2;
    lo  = (len >= 2) ? ram[a1] : 8'h00;
    hi  = (len == 3) ? ram[a2] : 8'h00;
    chk({tag, ".rd"}, mem_rd, 1);
    chk({tag, ".addr"}, mem_addr, mpc);
    if (early) begin
      exec_done     = 1'b1;
      pc_load       = 1'b1;
      pc_load_value = 16'($urandom);
    end
    n = 0;
    while (!instr_valid && !halted && n < 64) begin
      @(negedge clk);
      exec_done = 1'b0;
      pc_load   = 1'b0;
      n++;
    end
    if (op == 8'h01) begin
      chk({tag, ".hlt_lat"}, n, 4);
      chk({tag, ".halted"}, {halted, instr_valid}, 2'b10);
      chk({tag, ".hstate"}, state, 7);
      chk({tag, ".hpc"}, pc, a1);
    end else begin
      chk({tag, ".lat"}, n, 4 * len);
      chk({tag, ".opc"}, opcode, op);
      chk({tag, ".lo"}, operand_lo, lo);
      chk({tag, ".hi"}, operand_hi, hi);
      chk({tag, ".ill"}, illegal_op, !legal(op));
      chk({tag, ".pc"}, pc, 16'(mpc + 16'(len)));
    end
    mpc = mpc + 16'(len);
  endtask

  // Stays in S_EXECUTE with stray pc_load pulses, which must change nothing.
  task automatic hold(input int cyc);
    logic [7:0] op;
    op = opcode;
    for (int i = 0; i < cyc; i++) begin
      pc_load       = 1'($urandom);
      pc_load_value = 16'($urandom);
      @(negedge clk);
    end
    pc_load = 1'b0;
    chk("hold.valid", instr_valid, 1);
    chk("hold.pc", pc, mpc);
    chk("hold.op", opcode, op);
  endtask

  task automatic finish_exec(input bit redirect, input logic [15:0] tgt);
    exec_done     = 1'b1;
    pc_load       = redirect;
    pc_load_value = tgt;
    @(negedge clk);
    exec_done = 1'b0;
    pc_load   = 1'b0;
    if (redirect) mpc = tgt;
  endtask

  initial begin
    logic [7:0]  op;
    logic [15:0] tgt;
    bit          rd;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;

    put(RV, 8'h00, 8'h00, 8'h00);
    reset_start();
    check_fetch("nop", 1'b0);
    hold(3);

    put(mpc, 8'h0C, 8'h5A, 8'h00);
    finish_exec(1'b0, 16'h0);
    check_fetch("ldi", 1'b1);

    put(mpc, 8'h0A, 8'h34, 8'h12);
    finish_exec(1'b0, 16'h0);
    check_fetch("lda", 1'b0);

    put(mpc, 8'h00, 8'h00, 8'h00);
    finish_exec(1'b0, 16'h0);
    check_fetch("nop2", 1'b0);

    ram[16'hFFFF] = 8'h0C;
    ram[16'h0000] = 8'h77;
    finish_exec(1'b1, 16'hFFFF);
    check_fetch("wrap", 1'b0);

    put(mpc, 8'hEE, 8'h00, 8'h00);
    finish_exec(1'b0, 16'h0);
    check_fetch("ill", 1'b0);

    for (int k = 0; k < 150; k++) begin
      rd  = ($urandom_range(0, 3) == 0);
      tgt = 16'($urandom);
      if (rd) mpc = tgt;
      case ($urandom_range(0, 3))
        0: op = 8'h00;
        1: op = 8'h0C;
        2: op = 8'h0A;
        default: begin
          op = 8'($urandom);
          while (legal(op)) op = 8'($urandom);
        end
      endcase
      put(mpc, op, 8'($urandom), 8'($urandom));
      finish_exec(rd, tgt);
      check_fetch("rnd", $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) hold($urandom_range(1, 3));
    end

    // Reset during the opcode read of an LDA behind a non-zero opcode.
    put(mpc, 8'h0C, 8'h11, 8'h00);
    finish_exec(1'b0, 16'h0);
    check_fetch("pre", 1'b0);
    put(mpc, 8'h0A, 8'h22, 8'h33);
    finish_exec(1'b0, 16'h0);
    @(negedge clk);
    chk("mid.state", state, 3);
    reset = 1'b1;
    #1;
    chk("mid.rstate", state, 0);
    chk("mid.pc", pc, 0);
    chk("mid.op", opcode, 0);
    chk("mid.valid", instr_valid, 0);
    reset_start();
    check_fetch("refetch", 1'b0);

    put(mpc, 8'h01, 8'h00, 8'h00);
    finish_exec(1'b0, 16'h0);
    check_fetch("hlt", 1'b0);
    for (int i = 0; i < 50; i++) begin
      exec_done     = 1'($urandom);
      pc_load       = 1'($urandom);
      pc_load_value = 16'($urandom);
      @(negedge clk);
      chk("halt.rd_valid", {mem_rd, instr_valid, halted}, 3'b001);
    end
    exec_done = 1'b0;
    pc_load   = 1'b0;
    chk("halt.pc", pc, mpc);
    reset_start();
    check_fetch("after_halt", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got %0d exp %0d", 0, 1);
    $fatal(1);
  end
endmodule
